// File: rtl/div_iter.sv
// Radix-2 restoring divider for the EX stage: one quotient bit per clock,
// result_o = {remainder, quotient}, held while start_i stays high.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dividend;   // shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;
  logic               r_quo_neg;
  logic               r_rem_neg;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic               w_op1_neg;
  logic               w_op2_neg;
  logic [WIDTH-1:0]   w_op1_abs;
  logic [WIDTH-1:0]   w_op2_abs;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_sub;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_quo_final;
  logic [WIDTH-1:0]   w_rem_final;

  assign w_op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign w_op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign w_op1_abs = w_op1_neg ? -opdata1_i : opdata1_i;
  assign w_op2_abs = w_op2_neg ? -opdata2_i : opdata2_i;

  // Partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
  assign w_shift  = {r_rem, r_dividend[WIDTH-1]};
  assign w_sub    = {1'b0, w_shift} - {2'b00, r_divisor};
  assign w_borrow = w_sub[WIDTH+1];

  assign w_quo_final = r_quo_neg ? -r_dividend : r_dividend;
  assign w_rem_final = r_rem_neg ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FREE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo_neg  <= 1'b0;
      r_rem_neg  <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        S_FREE: begin
          r_ready  <= 1'b0;
          r_result <= '0;
          if (start_i && !annul_i) begin
            r_dividend <= w_op1_abs;
            r_divisor  <= w_op2_abs;
            r_rem      <= '0;
            r_quo_neg  <= w_op1_neg ^ w_op2_neg;
            r_rem_neg  <= w_op1_neg;
            r_cnt      <= '0;
            r_state    <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          r_result <= '0;
          r_ready  <= 1'b1;
          r_state  <= S_END;
        end
        S_ON: begin
          if (annul_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_state  <= S_FREE;
          end else if (r_cnt != CNT_W'(WIDTH)) begin
            r_rem      <= w_borrow ? w_shift[WIDTH-1:0] : w_sub[WIDTH-1:0];
            r_dividend <= {r_dividend[WIDTH-2:0], ~w_borrow};
            r_cnt      <= r_cnt + CNT_W'(1);
          end else begin
            r_result <= {w_rem_final, w_quo_final};
            r_ready  <= 1'b1;
            r_state  <= S_END;
          end
        end
        S_END: begin
          if (!start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_state  <= S_FREE;
          end
        end
        default: begin
          r_state <= S_FREE;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench for div_iter: results, latency, hold/clear handshake,
// divide-by-zero, annul and mid-divide reset.
module tb_div_iter;

  localparam int WIDTH = 32;

  logic              clk;
  logic              rst;
  logic              signed_div_i;
  logic [WIDTH-1:0]  opdata1_i;
  logic [WIDTH-1:0]  opdata2_i;
  logic              start_i;
  logic              annul_i;
  logic [63:0]       result_o;
  logic              ready_o;

  int n_tests;
  int n_fail;

  div_iter #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full transaction: start, scramble operands after the start edge, measure
  // latency, check hold while start stays high, then check clear on release.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    logic seen;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opdata1_i    = ~a;
    opdata2_i    = 32'h0000_0003;
    signed_div_i = ~sgn;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_o) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_ready"}, 64'(seen), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result_o, exp);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_clr"}, {ready_o, result_o}, 65'd0);
    $display("[TB] %s a=%h b=%h signed=%0d result=%h latency=%0d", tag, a, b, sgn, exp, lat);
  endtask

  // Run n cycles and report whether ready_o was ever seen high.
  task automatic watch_idle(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div("divu_100_7",   1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33);
    do_div("div_m7_2",     1'b1, 32'hFFFFFFF9,  32'h2,         64'hFFFFFFFF_FFFFFFFD, 33);
    do_div("div_7_m2",     1'b1, 32'h7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33);
    do_div("div_m100_m7",  1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 33);
    do_div("div_ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33);
    do_div("divu_big_m1",  1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 33);
    do_div("divu_max_1",   1'b0, 32'hFFFFFFFF,  32'h1,         64'h00000000_FFFFFFFF, 33);
    do_div("div_byzero",   1'b0, 32'h1234,      32'h0,         64'h0,                 1);

    // start with annul in FREE must not begin a divide
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    start_i = 1'b1; annul_i = 1'b1;
    watch_idle(40, seen);
    check("start_annul_nostart", 64'(seen), 64'd0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    $display("[TB] start+annul in FREE: ready seen=%0d", seen);

    // annul at iteration 10
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    watch_idle(40, seen);
    check("annul_noready", 64'(seen), 64'd0);
    check("annul_result", result_o, 64'd0);
    $display("[TB] annul at iter 10: ready seen=%0d", seen);
    do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // synchronous reset in the middle of a divide
    @(negedge clk);
    opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out", {ready_o, result_o}, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_idle(40, seen);
    check("midrst_noready", 64'(seen), 64'd0);
    $display("[TB] reset mid-divide: ready seen=%0d", seen);
    do_div("after_rst_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
